if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage; feeds the ID stage of the 5-stage pa core.
//  - Owns the PC and issues req/gnt fetches to instruction memory.
//  - Buffers returned words with their PC in a small FIFO and presents them to ID with a valid/ready handshake.
//  - Flushes and restarts on redirects (branch/jump/flush) from EX.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC of the first fetch after reset
//  FIFO_DEPTH  2              fetch buffer entries = max in-flight+buffered; power of 2, >=2
// PORTS
//  clk_i          in   1   clock; all state updates on rising edge
//  rst_i          in   1   synchronous reset, active-high
//  imem_req_o     out  1   fetch request valid
//  imem_addr_o    out  32  fetch address, word aligned
//  imem_gnt_i     in   1   request accepted this cycle (req && gnt = handshake)
//  imem_rvalid_i  in   1   response valid; responses return in request order, >=1 cycle after gnt
//  imem_rdata_i   in   32  instruction word
//  redirect_i     in   1   flush and restart at redirect_pc_i
//  redirect_pc_i  in   32  new fetch PC
//  id_ready_i     in   1   ID accepts the presented instruction
//  if_valid_o     out  1   instruction presented to ID
//  if_pc_o        out  32  PC of presented instruction
//  if_instr_o     out  32  presented instruction
//  if_misalign_o  out  1   misaligned-fetch exception flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: pc=RESET_PC; FIFOs empty; outstanding=0; discard=0; imem_req_o=0.
//    - Reset outputs: if_valid_o=0, if_pc_o=0, if_instr_o=NOP_INSTR, if_misalign_o=0.
//    - First request is issued in the first cycle after rst_i falls.
//    - rst_i mid-operation abandons all in-flight requests; responses arriving after reset are dropped.
//  - Credit: imem_req_o = !rst_i && (outstanding + fifo_count) < FIFO_DEPTH; imem_addr_o = pc.
//    - addr is held while req && !gnt unless a redirect occurs.
//  - On handshake: push pc into in-flight PC queue; pc <= pc+4 (mod 2^32, wraps 0xFFFF_FFFC -> 0); outstanding++.
//  - On rvalid:
//    - If discard>0: drop the response, discard--.
//    - Else: pop PC queue and push {pc, rdata} into fetch FIFO.
//    - outstanding-- in both cases.
//  - Latency: a response accepted in cycle N is visible on if_* in cycle N+1; no combinational path imem_* -> if_*.
//  - ID: if_valid_o = !fifo_empty; head popped when if_valid_o && id_ready_i.
//    - Outputs are held stable while !id_ready_i.
//    - When empty: if_pc_o=0, if_instr_o=NOP_INSTR.
//  - Redirect (highest priority):
//    - Fetch FIFO and PC queue cleared; pc <= {redirect_pc_i[31:2],2'b00}.
//    - discard <= outstanding after this cycle's gnt/rvalid (a grant in the same cycle is discarded; a response in the same cycle is dropped).
//    - A pop in the same cycle is ignored.
//    - New requests may issue from the next cycle.
//  - Full: never overflows; credit guarantees a slot for every in-flight response.
//  - gnt with no req is ignored. rvalid with outstanding=0 is a protocol error: assertion, ignored.
// CONFIGURATION
//  - PA_IF_MISALIGN_CHK_EN defined, and redirect_pc_i[1:0]!=0:
//    - Enter HALT: imem_req_o=0.
//    - if_valid_o=1, if_misalign_o=1, if_pc_o=redirect_pc_i (unmasked), if_instr_o=NOP_INSTR.
//    - State held regardless of id_ready_i until the next aligned redirect or reset.
//    - In-flight responses are still discarded.
//  - PA_IF_MISALIGN_CHK_EN undefined: redirect_pc_i[1:0] ignored; if_misalign_o tied 0; no HALT state.
// STRUCTURE
//  - riscv_pkg: XLEN=32, NOP_INSTR=32'h0000_0013.
//  - pa_pkg: typedef struct packed if_id_t {valid, pc, instr, misalign}.
//  - Sub-module fetch_fifo #(WIDTH, DEPTH): sync FIFO with push/pop/clear and count.
//    - Instanced twice: PC queue (WIDTH=32) and fetch FIFO (WIDTH=64).
// TESTING
//  1. Reset release, gnt=1, 1-cycle rvalid, id_ready=1:
//     -> addr 0x0,0x4,0x8...; if_pc 0x0 two cycles after first req; one instruction per cycle.
//  2. id_ready=0 for 10 cycles:
//     -> at most 2 requests; if_* stable on first word; resumes in order when ready=1.
//  3. gnt withheld 3 cycles at addr 0x8:
//     -> addr held at 0x8; no duplicate or skipped PC.
//  4. redirect_pc=0x100 with 2 responses in flight:
//     -> both dropped; next if_pc=0x100, then 0x104.
//  5. RESET_PC=32'hFFFF_FFF8:
//     -> fetch 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
//  6. MISALIGN_CHK_EN, redirect_pc=0x102:
//     -> req=0, if_valid=1, if_misalign=1, if_pc=0x102 held.
//     Then redirect 0x200: normal fetch at 0x200.

Source files
------------

// File: rtl/pa_pkg.sv
// Types shared between the pa core pipeline stages.
package pa_pkg;

  import riscv_pkg::*;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misalign;
  } if_id_t;

  typedef enum logic {
    IF_RUN,
    IF_HALT
  } if_state_e;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/riscv_pkg.sv
// Core-wide RISC-V constants shared by every pipeline stage.
package riscv_pkg;

  localparam int unsigned      XLEN      = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/clear and occupancy count; DEPTH must be a power of 2, >= 2.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t             wr_ptr_q;
  ptr_t             rd_ptr_q;
  cnt_t             count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == cnt_t'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      count_q <= count_q + cnt_t'(do_push) - cnt_t'(do_pop);
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, credit-limited imem req/gnt fetch, fetch buffer, redirect flush.
// Optional misaligned-redirect HALT state enabled by defining PA_IF_MISALIGN_CHK_EN.
module if_stage
  import riscv_pkg::*, pa_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            id_ready_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic            if_misalign_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  typedef logic [CW-1:0] cnt_t;

  logic [XLEN-1:0]   pc_q, pc_d;
  cnt_t              outstanding_q, outstanding_d;
  cnt_t              discard_q, discard_d;
  logic              halted;
  logic              handshake, rsp, drop, accept, pop;
  logic [XLEN-1:0]   pcq_rdata;
  cnt_t              pcq_count;
  logic              pcq_empty;
  logic [2*XLEN-1:0] ff_rdata;
  cnt_t              ff_count;
  logic              ff_empty;
  if_id_t            if_id;

  // Every in-flight request owns a fetch-buffer slot, so a response can never overflow.
  assign imem_req_o  = !rst_i && !halted && ((outstanding_q + ff_count) < cnt_t'(FIFO_DEPTH));
  assign imem_addr_o = pc_q;
  assign handshake   = imem_req_o && imem_gnt_i;
  assign rsp         = imem_rvalid_i && (outstanding_q != '0);
  assign drop        = rsp && (discard_q != '0);
  assign accept      = rsp && !drop;
  assign pop         = !ff_empty && id_ready_i && !redirect_i;

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + cnt_t'(handshake) - cnt_t'(rsp);
    discard_d     = discard_q - cnt_t'(drop);
    if (handshake) pc_d = pc_q + XLEN'(4);
    // Everything still outstanding after this cycle belongs to the abandoned path.
    if (redirect_i) begin
      pc_d      = align_pc(redirect_pc_i);
      discard_d = outstanding_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

`ifdef PA_IF_MISALIGN_CHK_EN
  if_state_e       state_q, state_d;
  logic [XLEN-1:0] halt_pc_q, halt_pc_d;

  always_comb begin
    state_d   = state_q;
    halt_pc_d = halt_pc_q;
    if (redirect_i) begin
      if (redirect_pc_i[1:0] != 2'b00) begin
        state_d   = IF_HALT;
        halt_pc_d = redirect_pc_i;
      end else begin
        state_d   = IF_RUN;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IF_RUN;
      halt_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      halt_pc_q <= halt_pc_d;
    end
  end

  assign halted = (state_q == IF_HALT);
`else
  assign halted = 1'b0;
`endif

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (redirect_i),
    .push_i  (handshake),
    .pop_i   (accept),
    .wdata_i (pc_q),
    .rdata_o (pcq_rdata),
    .count_o (pcq_count),
    .empty_o (pcq_empty)
  );

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_fetch_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (redirect_i),
    .push_i  (accept),
    .pop_i   (pop),
    .wdata_i ({pcq_rdata, imem_rdata_i}),
    .rdata_o (ff_rdata),
    .count_o (ff_count),
    .empty_o (ff_empty)
  );

  always_comb begin
    // NOTE: every field gets a default first so no path through this block infers a latch.
    if_id.valid    = 1'b0;
    if_id.pc       = '0;
    if_id.instr    = NOP_INSTR;
    if_id.misalign = 1'b0;
    if (!ff_empty) begin
      if_id.valid = 1'b1;
      if_id.pc    = ff_rdata[2*XLEN-1:XLEN];
      if_id.instr = ff_rdata[XLEN-1:0];
    end
`ifdef PA_IF_MISALIGN_CHK_EN
    if (state_q == IF_HALT) begin
      if_id.valid    = 1'b1;
      if_id.pc       = halt_pc_q;
      if_id.instr    = NOP_INSTR;
      if_id.misalign = 1'b1;
    end
`endif
  end

  assign if_valid_o    = if_id.valid;
  assign if_pc_o       = if_id.pc;
  assign if_instr_o    = if_id.instr;
  assign if_misalign_o = if_id.misalign;

  a_rvalid_expected: assert property (@(posedge clk_i) disable iff (rst_i)
    !(imem_rvalid_i && (outstanding_q == '0)));
  a_pc_queue_tracks: assert property (@(posedge clk_i) disable iff (rst_i)
    (pcq_count == (outstanding_q - discard_q)) && !(accept && pcq_empty));

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: in-order memory responder, queue-level reference model, directed scenarios.
module tb_if_stage;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i = 1'b1;
  logic        imem_req_o, if_valid_o, if_misalign_o;
  logic [31:0] imem_addr_o, if_pc_o, if_instr_o;
  logic        imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0, id_ready_i = 1'b1;
  logic [31:0] redirect_pc_i = '0;

  logic        w_req, w_valid, w_misalign;
  logic [31:0] w_addr, w_pc, w_instr;
  logic        w_rvalid = 1'b0;
  logic [31:0] w_rdata = '0;

  if_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .id_ready_i(id_ready_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_instr_o(if_instr_o),
    .if_misalign_o(if_misalign_o)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) u_wrap (
    .clk_i(clk), .rst_i(rst_i), .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_gnt_i(1'b1), .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
    .redirect_i(1'b0), .redirect_pc_i(32'h0), .id_ready_i(1'b1),
    .if_valid_o(w_valid), .if_pc_o(w_pc), .if_instr_o(w_instr),
    .if_misalign_o(w_misalign)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hBAD0_BAD0;
  endfunction

  typedef struct {
    logic [31:0] pc;
    bit          live;
  } flight_t;

  flight_t     m_flight[$];
  logic [31:0] m_out[$];
  logic [31:0] m_pc = '0;
  bit          m_halt = 1'b0;
  logic [31:0] m_halt_pc = '0;
  logic [31:0] mem_q[$], w_mem_q[$];
  logic [31:0] hs_log[$], pop_log[$], w_addr_log[$], w_pop_log[$];
  bit          gnt_en = 1'b1, rv_en = 1'b1, chk_en = 1'b0;
  int          cyc = 0, first_req_cyc = -1, first_vld_cyc = -1;

  // Compare, respond and advance the model once per cycle, away from the rising edge.
  always @(negedge clk) begin
    logic    hs;
    logic    do_pop;
    flight_t f;
    cyc++;
    if (chk_en) begin
      check("req", imem_req_o,
            !rst_i && !m_halt && ((m_flight.size() + m_out.size()) < DEPTH));
      if (!m_halt) check("addr", imem_addr_o, m_pc);
      if (m_halt) begin
        check("halt_valid", if_valid_o, 1'b1);
        check("halt_pc", if_pc_o, m_halt_pc);
        check("halt_instr", if_instr_o, NOP);
        check("halt_misalign", if_misalign_o, 1'b1);
      end else if (m_out.size() > 0) begin
        check("valid", if_valid_o, 1'b1);
        check("pc", if_pc_o, m_out[0]);
        check("instr", if_instr_o, mem_word(m_out[0]));
        check("misalign", if_misalign_o, 1'b0);
      end else begin
        check("idle_valid", if_valid_o, 1'b0);
        check("idle_pc", if_pc_o, 32'h0);
        check("idle_instr", if_instr_o, NOP);
        check("idle_misalign", if_misalign_o, 1'b0);
      end
      if (w_valid) check("wrap_instr", w_instr, mem_word(w_pc));
      check("wrap_misalign", w_misalign, 1'b0);
    end

    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    w_rvalid      = 1'b0;
    w_rdata       = '0;
    imem_gnt_i    = gnt_en;

    if (rst_i) begin
      m_flight.delete(); m_out.delete(); mem_q.delete(); w_mem_q.delete();
      m_pc = 32'h0; m_halt = 1'b0;
    end else begin
      if (if_valid_o && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (rv_en && mem_q.size() > 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(mem_q.pop_front());
      end
      do_pop = (m_out.size() > 0) && id_ready_i && !redirect_i && !m_halt;
      if (do_pop) pop_log.push_back(m_out.pop_front());
      if (imem_rvalid_i && m_flight.size() > 0) begin
        f = m_flight.pop_front();
        if (f.live) m_out.push_back(f.pc);
      end
      hs = imem_req_o && imem_gnt_i;
      if (hs) begin
        mem_q.push_back(imem_addr_o);
        m_flight.push_back('{pc: m_pc, live: 1'b1});
        hs_log.push_back(imem_addr_o);
        if (first_req_cyc < 0) first_req_cyc = cyc;
      end
      if (redirect_i) begin
        foreach (m_flight[i]) m_flight[i].live = 1'b0;
        m_out.delete();
        m_pc = redirect_pc_i & ~32'h3;
`ifdef PA_IF_MISALIGN_CHK_EN
        m_halt    = (redirect_pc_i[1:0] != 2'b00);
        m_halt_pc = redirect_pc_i;
`endif
      end else if (hs) begin
        m_pc = m_pc + 32'd4;
      end

      if (w_valid) w_pop_log.push_back(w_pc);
      if (w_mem_q.size() > 0) begin
        w_rvalid = 1'b1;
        w_rdata  = mem_word(w_mem_q.pop_front());
      end
      if (w_req) begin
        w_mem_q.push_back(w_addr);
        w_addr_log.push_back(w_addr);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    step(1);
    redirect_i    = 1'b0;
    pop_log.delete();
  endtask

  initial begin
    logic [31:0] held_pc;
    int          h0;

    step(2);
    chk_en = 1'b1;
    step(1);
    check("rst_valid", if_valid_o, 1'b0);
    check("rst_pc", if_pc_o, 32'h0);
    check("rst_instr", if_instr_o, NOP);
    check("rst_misalign", if_misalign_o, 1'b0);
    check("rst_req", imem_req_o, 1'b0);
    rst_i = 1'b0;

    // Streaming from reset with immediate grants and one-cycle responses.
    step(14);
    check("t1_addr0", qget(hs_log, 0), 32'h0);
    check("t1_addr1", qget(hs_log, 1), 32'h4);
    check("t1_addr2", qget(hs_log, 2), 32'h8);
    check("t1_latency", first_vld_cyc - first_req_cyc, 2);
    check("t1_pop0", qget(pop_log, 0), 32'h0);
    check("t1_pop1", qget(pop_log, 1), 32'h4);
    check("t1_pop3", qget(pop_log, 3), 32'hC);

    // ID back-pressure: outputs frozen, fetch bounded by credit.
    id_ready_i = 1'b0;
    h0 = hs_log.size();
    step(1);
    held_pc = if_pc_o;
    step(9);
    check("t2_valid", if_valid_o, 1'b1);
    check("t2_stable", if_pc_o, held_pc);
    check("t2_req_bound", (hs_log.size() - h0) <= 2, 1'b1);
    pop_log.delete();
    id_ready_i = 1'b1;
    step(8);
    check("t2_resume0", qget(pop_log, 0), held_pc);
    check("t2_resume1", qget(pop_log, 1), held_pc + 32'd4);

    // Grant withheld at 0x8: address must hold, no skip or duplicate.
    gnt_en = 1'b0;
    redirect(32'h8);
    repeat (3) begin
      check("t3_addr_hold", imem_addr_o, 32'h8);
      step(1);
    end
    gnt_en = 1'b1;
    step(12);
    check("t3_pop0", qget(pop_log, 0), 32'h8);
    check("t3_pop1", qget(pop_log, 1), 32'hC);
    check("t3_pop2", qget(pop_log, 2), 32'h10);

    // Redirect with two responses still in flight.
    rv_en = 1'b0;
    step(4);
    check("t4_inflight", mem_q.size(), 2);
    redirect(32'h100);
    rv_en = 1'b1;
    step(10);
    check("t4_pop0", qget(pop_log, 0), 32'h100);
    check("t4_pop1", qget(pop_log, 1), 32'h104);

    // Misaligned redirect target.
    redirect(32'h102);
`ifdef PA_IF_MISALIGN_CHK_EN
    step(2);
    id_ready_i = 1'b0;
    step(2);
    id_ready_i = 1'b1;
    step(2);
    check("t6_req", imem_req_o, 1'b0);
    check("t6_valid", if_valid_o, 1'b1);
    check("t6_misalign", if_misalign_o, 1'b1);
    check("t6_pc", if_pc_o, 32'h102);
    check("t6_instr", if_instr_o, NOP);
    redirect(32'h200);
    step(10);
    check("t6_resume", qget(pop_log, 0), 32'h200);
`else
    step(10);
    check("t6_aligned", qget(pop_log, 0), 32'h100);
    check("t6_no_misalign", if_misalign_o, 1'b0);
`endif

    // Mixed stall/back-pressure/redirect traffic, checked every cycle by the model.
    for (int i = 0; i < 400; i++) begin
      gnt_en     = ($urandom_range(0, 3) != 0);
      rv_en      = ($urandom_range(0, 3) != 0);
      id_ready_i = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 24) == 0) begin
        redirect_i    = 1'b1;
        redirect_pc_i = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0
                                                    : 32'h1000 + ($urandom_range(0, 63) << 2);
      end else begin
        redirect_i = 1'b0;
      end
      step(1);
    end
    redirect_i = 1'b0;
    rv_en      = 1'b1;
    step(4);

    // Fetch from a reset PC just below the top of the address space.
    check("t5_addr0", qget(w_addr_log, 0), 32'hFFFF_FFF8);
    check("t5_addr1", qget(w_addr_log, 1), 32'hFFFF_FFFC);
    check("t5_addr2", qget(w_addr_log, 2), 32'h0000_0000);
    check("t5_pc0", qget(w_pop_log, 0), 32'hFFFF_FFF8);
    check("t5_pc1", qget(w_pop_log, 1), 32'hFFFF_FFFC);
    check("t5_pc2", qget(w_pop_log, 2), 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
